btb_update_ctrl: RTL and testbench
==================================

// Module: btb_update_ctrl
// PURPOSE
//  Sequences branch-resolution updates into the branch target buffer (BTB) through its single shared search/write port.
//  Queues resolutions from execute, searches the BTB for each PC, then issues one write: a 2-bit counter update on a hit,
//  or a round-robin allocation on a taken miss. Always yields the port to fetch-side prediction lookups.
// PARAMETERS
//  ENTRIES  2048  BTB entry count (power of 2)
//  IDX_W    11    log2(ENTRIES)
//  QDEPTH   4     resolution queue depth (power of 2, >=2)
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous, active-low reset
//  res_valid    in   1      resolution record offered
//  res_ready    out  1      queue can accept; transfer = res_valid & res_ready
//  res_pc       in   32     branch PC
//  res_target   in   32     resolved target address
//  res_taken    in   1      resolved direction
//  flush        in   1      drop all queued and in-flight updates
//  fetch_busy   in   1      fetch owns the BTB port this cycle
//  btb_req      out  1      port request (search when btb_we=0)
//  btb_we       out  1      write qualifier
//  btb_idx      out  IDX_W  write index
//  btb_wtag     out  32     search key / write tag (PC)
//  btb_wtarget  out  32     write target
//  btb_wctr     out  2      write counter
//  btb_rhit     in   1      search hit; valid in the cycle after the search req
//  btb_ridx     in   IDX_W  hit index
//  btb_rctr     in   2      hit entry counter
//  btb_rtarget  in   32     hit entry target
//  busy         out  1      queue non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset (rst=0 at posedge): queue empty, FSM=IDLE, victim pointer=0; all outputs 0 except res_ready=1.
//  res_ready = !full & !flush. Full queue plus a pop in the same cycle does not free a slot that cycle.
//  FSM states:
//   IDLE: if queue non-empty & !fetch_busy: btb_req=1, btb_we=0, btb_wtag=head.pc; go to WAIT. Otherwise stay.
//   WAIT: capture btb_rhit/ridx/rctr/rtarget into registers; go to WRITE. This is the only cycle the inputs are sampled.
//   WRITE: stay while fetch_busy. Otherwise:
//    hit:  btb_req=btb_we=1, idx=ridx, tag=pc, ctr=sat(rctr±1: taken +1 max 3, not-taken -1 min 0),
//          target=taken ? res_target : rtarget.
//    miss & taken:  write idx=victim, ctr=2'b10, target=res_target; victim <= victim+1, wrapping at ENTRIES-1 -> 0.
//    miss & !taken: no write.
//   In every WRITE case the queue head pops and the FSM returns to IDLE.
//  Latency without contention: record accepted at edge E. Search req in cycle E+1, capture in E+2, write in E+3.
//  Back-to-back issue: one record per 3 cycles.
//  Only one record is in flight at a time, so there is no read-after-write hazard on the same PC.
//  btb_req is never high while fetch_busy=1 or flush=1.
//  flush: btb_req is suppressed in the same cycle. Next edge: queue empty, FSM=IDLE, victim unchanged.
//   A res_valid arriving in the flush cycle is dropped.
//  Reset mid-operation discards everything; no partial write is ever issued.
// CONFIGURATION
//  BTB_UPD_STATS_EN defined: add outputs stat_upd (32), stat_alloc (32) and stat_stall (32).
//   stat_upd counts hit writes, stat_alloc counts allocations, stat_stall counts cycles with a pending
//   req blocked by fetch_busy. All wrap at 2^32, reset to 0 and are not cleared by flush.
//  BTB_UPD_STATS_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  Package bp_pkg: btb_res_t struct {pc, target, taken}, FSM enum {IDLE, WAIT, WRITE},
//   CTR_WEAK_T=2'b10, CTR_MAX=2'b11, sat_ctr() function.
//  Sub-module bp_res_fifo: parameterised btb_res_t FIFO with sync active-low reset and a flush input.
//  The FSM and victim pointer live in the top level.
// TESTING
//  1 Single taken res pc=0x100, tgt=0x200, BTB miss -> cycle E+3 write idx=0, ctr=2, tgt=0x200; victim=1.
//  2 Res pc=0x100 not-taken, BTB hit ridx=5, rctr=3, rtarget=0x200 -> write idx=5, ctr=2, target 0x200 kept.
//  3 Taken hit with rctr=3 -> ctr stays 3. Not-taken hit with rctr=0 -> ctr stays 0. Not-taken miss -> no btb_we, pop only.
//  4 fetch_busy held 4 cycles during WRITE -> btb_req low throughout; write issued in the first free cycle
//    with unchanged fields.
//  5 Push 5 records back-to-back, QDEPTH=4 -> res_ready low after the 4th; all 5 written in order; busy drops after the last.
//  6 flush asserted in WAIT with 3 queued -> no write; next cycle busy=0, res_ready=1; victim unchanged.
//    Allocating ENTRIES+1 misses wraps victim to 0 then 1.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the BTB update controller and its resolution FIFO.
package bp_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } btb_res_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } upd_state_e;

    localparam logic [1:0] CTR_WEAK_T = 2'b10;
    localparam logic [1:0] CTR_MAX    = 2'b11;

    // Saturating 2-bit direction counter step.
    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_res_fifo.sv
// Resolution-record FIFO with synchronous active-low reset and a synchronous flush that empties it.
module bp_res_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     push,
    input  btb_res_t din,
    input  logic     pop,
    output btb_res_t dout,
    output logic     empty,
    output logic     full
);
    localparam int AW = $clog2(DEPTH);

    btb_res_t        mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;
    logic [AW:0]     wr_ptr_d;
    logic [AW:0]     rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = (push && !full)  ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = (pop  && !empty) ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// Serialises branch resolutions into the BTB via its shared search/write port (search, capture, write).
// Optional statistics counters are enabled by defining BTB_UPD_STATS_EN.
module btb_update_ctrl
    import bp_pkg::*;
#(
    parameter int ENTRIES = 2048,
    parameter int IDX_W   = 11,
    parameter int QDEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [31:0]      res_pc,
    input  logic [31:0]      res_target,
    input  logic             res_taken,
    input  logic             flush,
    input  logic             fetch_busy,
    output logic             btb_req,
    output logic             btb_we,
    output logic [IDX_W-1:0] btb_idx,
    output logic [31:0]      btb_wtag,
    output logic [31:0]      btb_wtarget,
    output logic [1:0]       btb_wctr,
    input  logic             btb_rhit,
    input  logic [IDX_W-1:0] btb_ridx,
    input  logic [1:0]       btb_rctr,
    input  logic [31:0]      btb_rtarget,
    output logic             busy
`ifdef BTB_UPD_STATS_EN
    ,
    output logic [31:0]      stat_upd,
    output logic [31:0]      stat_alloc,
    output logic [31:0]      stat_stall
`endif
);
    upd_state_e       state_q;
    logic             hit_q;
    logic [IDX_W-1:0] ridx_q;
    logic [1:0]       rctr_q;
    logic [31:0]      rtarget_q;
    logic [IDX_W-1:0] victim_q;
    logic [IDX_W-1:0] victim_d;

    btb_res_t head;
    btb_res_t in_rec;
    logic     q_empty;
    logic     q_full;
    logic     push;
    logic     search_go;
    logic     write_go;
    logic     has_write;
    logic     alloc_go;

    assign in_rec    = '{pc: res_pc, target: res_target, taken: res_taken};
    assign res_ready = !q_full && !flush;
    assign push      = res_valid && res_ready;
    assign busy      = !q_empty || (state_q != IDLE);

    // Port use is qualified by reset so a reset cycle never leaks a partial write.
    assign search_go = rst && !flush && !fetch_busy && (state_q == IDLE) && !q_empty;
    assign write_go  = rst && !flush && !fetch_busy && (state_q == WRITE);
    assign has_write = hit_q || head.taken;
    assign alloc_go  = write_go && !hit_q && head.taken;
    assign victim_d  = !alloc_go ? victim_q :
                       (victim_q == IDX_W'(ENTRIES - 1)) ? '0 : victim_q + IDX_W'(1);

    bp_res_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .din   (in_rec),
        .pop   (write_go),
        .dout  (head),
        .empty (q_empty),
        .full  (q_full)
    );

    always_comb begin
        btb_req     = 1'b0;
        btb_we      = 1'b0;
        btb_idx     = '0;
        btb_wtag    = '0;
        btb_wtarget = '0;
        btb_wctr    = '0;
        if (search_go) begin
            btb_req  = 1'b1;
            btb_wtag = head.pc;
        end else if (write_go && has_write) begin
            btb_req  = 1'b1;
            btb_we   = 1'b1;
            btb_wtag = head.pc;
            if (hit_q) begin
                btb_idx     = ridx_q;
                btb_wctr    = sat_ctr(rctr_q, head.taken);
                btb_wtarget = head.taken ? head.target : rtarget_q;
            end else begin
                btb_idx     = victim_q;
                btb_wctr    = CTR_WEAK_T;
                btb_wtarget = head.target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            hit_q     <= 1'b0;
            ridx_q    <= '0;
            rctr_q    <= '0;
            rtarget_q <= '0;
            victim_q  <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            victim_q <= victim_d;
            case (state_q)
                IDLE: begin
                    if (search_go) state_q <= WAIT;
                end
                WAIT: begin
                    hit_q     <= btb_rhit;
                    ridx_q    <= btb_ridx;
                    rctr_q    <= btb_rctr;
                    rtarget_q <= btb_rtarget;
                    state_q   <= WRITE;
                end
                WRITE: begin
                    if (write_go) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BTB_UPD_STATS_EN
    logic stall_c;
    assign stall_c = rst && !flush && fetch_busy &&
                     (((state_q == IDLE) && !q_empty) || ((state_q == WRITE) && has_write));

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_upd   <= '0;
            stat_alloc <= '0;
            stat_stall <= '0;
        end else begin
            if (write_go && hit_q) stat_upd <= stat_upd + 32'd1;
            if (alloc_go)          stat_alloc <= stat_alloc + 32'd1;
            if (stall_c)           stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: the bench plays the BTB, drives resolutions and checks each port cycle.
module tb_btb_update_ctrl;
    logic        clk;
    logic        rst;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_pc;
    logic [31:0] res_target;
    logic        res_taken;
    logic        flush;
    logic        fetch_busy;
    logic        btb_req;
    logic        btb_we;
    logic [10:0] btb_idx;
    logic [31:0] btb_wtag;
    logic [31:0] btb_wtarget;
    logic [1:0]  btb_wctr;
    logic        btb_rhit;
    logic [10:0] btb_ridx;
    logic [1:0]  btb_rctr;
    logic [31:0] btb_rtarget;
    logic        busy;
`ifdef BTB_UPD_STATS_EN
    logic [31:0] stat_upd;
    logic [31:0] stat_alloc;
    logic [31:0] stat_stall;
`endif

    int   tests_run;
    int   tests_failed;
    int   nw;
    int   na;
    logic acc;

    btb_update_ctrl #(.ENTRIES(2048), .IDX_W(11), .QDEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_pc      (res_pc),
        .res_target  (res_target),
        .res_taken   (res_taken),
        .flush       (flush),
        .fetch_busy  (fetch_busy),
        .btb_req     (btb_req),
        .btb_we      (btb_we),
        .btb_idx     (btb_idx),
        .btb_wtag    (btb_wtag),
        .btb_wtarget (btb_wtarget),
        .btb_wctr    (btb_wctr),
        .btb_rhit    (btb_rhit),
        .btb_ridx    (btb_ridx),
        .btb_rctr    (btb_rctr),
        .btb_rtarget (btb_rtarget),
        .busy        (busy)
`ifdef BTB_UPD_STATS_EN
        ,
        .stat_upd    (stat_upd),
        .stat_alloc  (stat_alloc),
        .stat_stall  (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One uncontended record: accept, search in E+1, capture in E+2, write (or not) in E+3.
    task automatic run_one(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic hit, input logic [10:0] ridx,
                           input logic [1:0] rctr, input logic [31:0] rtgt, input logic exp_we,
                           input logic [10:0] exp_idx, input logic [1:0] exp_ctr,
                           input logic [31:0] exp_tgt);
        btb_rhit = hit; btb_ridx = ridx; btb_rctr = rctr; btb_rtarget = rtgt;
        res_valid = 1'b1; res_pc = pc; res_target = tgt; res_taken = tk;
        #1;
        chk({tag, "_ready"}, 64'(res_ready), 64'd1);
        tick; res_valid = 1'b0; #1;
        chk({tag, "_sreq"}, 64'(btb_req), 64'd1);
        chk({tag, "_swe"}, 64'(btb_we), 64'd0);
        chk({tag, "_skey"}, 64'(btb_wtag), 64'(pc));
        tick; #1;
        chk({tag, "_waitreq"}, 64'(btb_req), 64'd0);
        chk({tag, "_waitbusy"}, 64'(busy), 64'd1);
        tick; #1;
        chk({tag, "_wreq"}, 64'(btb_req), 64'(exp_we));
        chk({tag, "_we"}, 64'(btb_we), 64'(exp_we));
        if (exp_we) begin
            chk({tag, "_idx"}, 64'(btb_idx), 64'(exp_idx));
            chk({tag, "_ctr"}, 64'(btb_wctr), 64'(exp_ctr));
            chk({tag, "_tgt"}, 64'(btb_wtarget), 64'(exp_tgt));
            chk({tag, "_tag"}, 64'(btb_wtag), 64'(pc));
        end
        $display("[TB] %s pc=0x%0h we=%0b idx=%0d ctr=%0d tgt=0x%0h",
                 tag, pc, btb_we, btb_idx, btb_wctr, btb_wtarget);
        tick; #1;
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst = 1'b0; res_valid = 1'b0; res_pc = '0; res_target = '0; res_taken = 1'b0;
        flush = 1'b0; fetch_busy = 1'b0;
        btb_rhit = 1'b0; btb_ridx = '0; btb_rctr = '0; btb_rtarget = '0;
        tick; tick; #1;
        chk("rst_req", 64'(btb_req), 64'd0);
        chk("rst_we", 64'(btb_we), 64'd0);
        chk("rst_idx", 64'(btb_idx), 64'd0);
        chk("rst_wtag", 64'(btb_wtag), 64'd0);
        chk("rst_wtgt", 64'(btb_wtarget), 64'd0);
        chk("rst_wctr", 64'(btb_wctr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(res_ready), 64'd1);
        rst = 1'b1;
        tick;

        run_one("t1_miss_alloc", 32'h100, 32'h200, 1'b1, 1'b0, 11'd0, 2'd0, 32'h0,
                1'b1, 11'd0, 2'd2, 32'h200);
        run_one("t2_nt_hit", 32'h100, 32'h104, 1'b0, 1'b1, 11'd5, 2'd3, 32'h200,
                1'b1, 11'd5, 2'd2, 32'h200);
        run_one("t3_t_hit_sat", 32'h140, 32'h600, 1'b1, 1'b1, 11'd7, 2'd3, 32'h500,
                1'b1, 11'd7, 2'd3, 32'h600);
        run_one("t3_nt_hit_sat", 32'h144, 32'h148, 1'b0, 1'b1, 11'd9, 2'd0, 32'h700,
                1'b1, 11'd9, 2'd0, 32'h700);
        run_one("t3_t_hit_inc", 32'h150, 32'h650, 1'b1, 1'b1, 11'd12, 2'd1, 32'h550,
                1'b1, 11'd12, 2'd2, 32'h650);
        run_one("t3_nt_hit_dec", 32'h154, 32'h158, 1'b0, 1'b1, 11'd13, 2'd2, 32'h750,
                1'b1, 11'd13, 2'd1, 32'h750);
        run_one("t3_nt_miss", 32'h160, 32'h164, 1'b0, 1'b0, 11'd0, 2'd0, 32'h0,
                1'b0, 11'd0, 2'd0, 32'h0);
        run_one("t3_victim1", 32'h400, 32'h800, 1'b1, 1'b0, 11'd0, 2'd0, 32'h0,
                1'b1, 11'd1, 2'd2, 32'h800);

        // fetch_busy held across four WRITE cycles
        btb_rhit = 1'b0;
        res_valid = 1'b1; res_pc = 32'h180; res_target = 32'h900; res_taken = 1'b1;
        #1;
        tick; res_valid = 1'b0; #1;
        chk("t4_search", 64'(btb_req), 64'd1);
        tick; #1;
        tick; fetch_busy = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_blocked", 64'(btb_req), 64'd0);
            chk("t4_busy", 64'(busy), 64'd1);
            if (i < 3) begin
                tick; #1;
            end
        end
        tick; fetch_busy = 1'b0; #1;
        chk("t4_we", 64'(btb_we), 64'd1);
        chk("t4_idx", 64'(btb_idx), 64'd2);
        chk("t4_ctr", 64'(btb_wctr), 64'd2);
        chk("t4_tgt", 64'(btb_wtarget), 64'h900);
        chk("t4_tag", 64'(btb_wtag), 64'h180);
        $display("[TB] t4 stalled write idx=%0d tgt=0x%0h", btb_idx, btb_wtarget);
        tick; #1;
        chk("t4_idle", 64'(busy), 64'd0);

        // five back-to-back records into a four-deep queue
        fetch_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            res_valid = 1'b1; res_pc = 32'h5000 + 32'(i * 4);
            res_target = 32'h6000 + 32'(i * 4); res_taken = 1'b1;
            #1;
            chk("t5_ready", 64'(res_ready), 64'd1);
            tick;
        end
        res_pc = 32'h5010; res_target = 32'h6010;
        #1;
        chk("t5_full", 64'(res_ready), 64'd0);
        chk("t5_noreq", 64'(btb_req), 64'd0);
        fetch_busy = 1'b0;
        #1;
        chk("t5_search", 64'(btb_req), 64'd1);
        chk("t5_key", 64'(btb_wtag), 64'h5000);
        nw = 0;
        for (int c = 0; c < 80; c++) begin
            if (nw == 5 && !busy) break;
            if (btb_we) begin
                if (nw == 0) chk("t5_full_pop", 64'(res_ready), 64'd0);
                chk("t5_tag", 64'(btb_wtag), 64'(32'h5000 + 32'(nw * 4)));
                chk("t5_idx", 64'(btb_idx), 64'(3 + nw));
                $display("[TB] t5 write %0d pc=0x%0h idx=%0d", nw, btb_wtag, btb_idx);
                nw++;
            end
            acc = res_valid && res_ready;
            tick;
            if (acc) res_valid = 1'b0;
            #1;
        end
        chk("t5_count", 64'(nw), 64'd5);
        chk("t5_busy", 64'(busy), 64'd0);

        // flush while a search result is being captured
        btb_rhit = 1'b0; fetch_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_pc = 32'h3000 + 32'(i * 4);
            res_target = 32'h3800; res_taken = 1'b1;
            #1;
            tick;
        end
        res_valid = 1'b0; fetch_busy = 1'b0;
        #1;
        chk("t6_search", 64'(btb_req), 64'd1);
        tick; flush = 1'b1; res_valid = 1'b1; res_pc = 32'h3ff0; #1;
        chk("t6_flush_req", 64'(btb_req), 64'd0);
        chk("t6_flush_ready", 64'(res_ready), 64'd0);
        tick; flush = 1'b0; res_valid = 1'b0; #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_ready", 64'(res_ready), 64'd1);
        chk("t6_req", 64'(btb_req), 64'd0);
        tick; #1;
        chk("t6_dropped", 64'(busy), 64'd0);
        $display("[TB] t6 flush done busy=%0b", busy);
        run_one("t6_victim", 32'h3100, 32'h3200, 1'b1, 1'b0, 11'd0, 2'd0, 32'h0,
                1'b1, 11'd8, 2'd2, 32'h3200);

        // reset during capture: no write, everything cleared
        res_valid = 1'b1; res_pc = 32'h7700; res_target = 32'h7800; res_taken = 1'b1;
        #1;
        tick; res_valid = 1'b0; #1;
        chk("mr_search", 64'(btb_req), 64'd1);
        tick; rst = 1'b0; #1;
        chk("mr_req0", 64'(btb_req), 64'd0);
        tick; #1;
        chk("mr_req1", 64'(btb_req), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        tick; #1;
        chk("mr_after_req", 64'(btb_req), 64'd0);
        chk("mr_after_busy", 64'(busy), 64'd0);

        // ENTRIES+1 allocations from a reset victim pointer
        btb_rhit = 1'b0; nw = 0; na = 0;
        res_valid = 1'b1; res_taken = 1'b1; res_pc = 32'h10000; res_target = 32'h20000;
        #1;
        for (int c = 0; c < 7000; c++) begin
            if (nw == 2049) break;
            if (btb_we) begin
                chk("wrap_idx", 64'(btb_idx), 64'(nw % 2048));
                chk("wrap_tag", 64'(btb_wtag), 64'(32'h10000 + 32'(nw * 4)));
                nw++;
            end
            acc = res_valid && res_ready;
            tick;
            if (acc) begin
                na++;
                if (na == 2049) begin
                    res_valid = 1'b0;
                end else begin
                    res_pc = 32'h10000 + 32'(na * 4);
                    res_target = 32'h20000 + 32'(na * 4);
                end
            end
            #1;
        end
        chk("wrap_count", 64'(nw), 64'd2049);
        $display("[TB] wrap allocations=%0d", nw);
        tick; #1;
        chk("wrap_idle", 64'(busy), 64'd0);
        run_one("wrap_victim1", 32'h9000, 32'h9100, 1'b1, 1'b0, 11'd0, 2'd0, 32'h0,
                1'b1, 11'd1, 2'd2, 32'h9100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
